// File: rtl/scalar_writeback_scheduler.sv
// Round-robin arbiter for the scalar register-file write port, with a busy
// scoreboard that stalls issue on RAW/WAW hazards against pending write-backs.
module scalar_writeback_scheduler #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic                 issue_has_rd,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        src1,
  input  logic [AW-1:0]        src2,
  output logic                 stall,
  output logic [7:0]           busy,
  output logic                 WE,
  output logic [AW-1:0]        destination_register,
  output logic [DW-1:0]        WD
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam logic [AW-1:0] R7 = AW'(7);

  // Handshake: a requester holds valid/rd/data stable until req_ready is 1 in
  // the same cycle; valid&ready is the transfer, and ready never depends on
  // anything but req_valid, the pointer and rst.

  logic [PW-1:0] ptr;
  logic [AW-1:0] rd_a   [NREQ];
  logic [DW-1:0] data_a [NREQ];

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            found;
  logic [PW-1:0]   idx;
  logic [AW-1:0]   grant_rd;
  logic [DW-1:0]   grant_data;
  logic            issue_set;
  logic [7:0]      busy_next;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rd_a[i]   = req_rd[i*AW +: AW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  // Search starts one past the last winner and wraps, so the winner drops to
  // lowest priority next cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = PW'((int'(ptr) + off) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    if (rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign req_ready  = grant;
  assign grant_rd   = rd_a[grant_idx];
  assign grant_data = data_a[grant_idx];

  // No bypass: busy is the registered view, so a same-cycle clear still stalls.
  assign stall = issue_valid &
                 (busy[src1] | busy[src2] | (issue_has_rd & busy[issue_rd]));

  assign issue_set = issue_valid & ~stall & issue_has_rd & (issue_rd != R7);

  // Set is applied after clear so a new producer wins over the old one's clear.
  always_comb begin
    busy_next = busy;
    if (found && grant_rd != R7) busy_next[grant_rd] = 1'b0;
    if (issue_set)               busy_next[issue_rd] = 1'b1;
    busy_next[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WE                   <= 1'b0;
      destination_register <= '0;
      WD                   <= '0;
      busy                 <= '0;
      ptr                  <= PW'(NREQ - 1);
    end else begin
      busy <= busy_next;
      WE   <= found && (grant_rd != R7);
      if (found) ptr <= grant_idx;
      // R7 lives outside the file, so its write-back leaves the port untouched.
      if (found && grant_rd != R7) begin
        destination_register <= grant_rd;
        WD                   <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_scalar_writeback_scheduler.sv
// Directed bench for scalar_writeback_scheduler: arbitration order, write-back
// latency, scoreboard set/clear, R7 handling and mid-operation reset.
module tb_scalar_writeback_scheduler;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic                 issue_has_rd;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        src1;
  logic [AW-1:0]        src2;
  logic                 stall;
  logic [7:0]           busy;
  logic                 WE;
  logic [AW-1:0]        destination_register;
  logic [DW-1:0]        WD;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] rr_rd   [3];
  logic [DW-1:0] rr_data [3];

  scalar_writeback_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_rd               (req_rd),
    .req_data             (req_data),
    .req_ready            (req_ready),
    .issue_valid          (issue_valid),
    .issue_has_rd         (issue_has_rd),
    .issue_rd             (issue_rd),
    .src1                 (src1),
    .src2                 (src2),
    .stall                (stall),
    .busy                 (busy),
    .WE                   (WE),
    .destination_register (destination_register),
    .WD                   (WD)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1ns after posedge, checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_rd[i*AW +: AW]     = rd;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic set_issue(input logic v, input logic has_rd, input logic [AW-1:0] rd,
                           input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    issue_valid  = v;
    issue_has_rd = has_rd;
    issue_rd     = rd;
    src1         = s1;
    src2         = s2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    set_issue(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_we",    32'(WE), 32'h0);
    check("rst_rd",    32'(destination_register), 32'h0);
    check("rst_wd",    32'(WD), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // 1. Single requester
    set_req(1, 1'b1, 3'd3, 16'hBEEF);
    settle();
    check("t1_ready", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 3'd0, 16'h0000);
    settle();
    check("t1_we",   32'(WE), 32'h1);
    check("t1_rd",   32'(destination_register), 32'h3);
    check("t1_wd",   32'(WD), 32'hBEEF);
    tick();
    check("t1_we_off", 32'(WE), 32'h0);
    check("t1_wd_hold", 32'(WD), 32'hBEEF);

    // 2. Round-robin fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_rd[0] = 3'd1; rr_data[0] = 16'h1111;
    rr_rd[1] = 3'd2; rr_data[1] = 16'h2222;
    rr_rd[2] = 3'd4; rr_data[2] = 16'h4444;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, rr_rd[i], rr_data[i]);
    settle();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
      tick();
      check($sformatf("t2_we_%0d", k), 32'(WE), 32'h1);
      check($sformatf("t2_rd_%0d", k), 32'(destination_register), 32'(rr_rd[k % 3]));
      check($sformatf("t2_wd_%0d", k), 32'(WD), 32'(rr_data[k % 3]));
    end
    req_valid = '0;
    tick();
    check("t2_we_off", 32'(WE), 32'h0);

    // 3. Scoreboard RAW (pointer now at 2, requester 0 is next)
    set_issue(1'b1, 1'b1, 3'd5, 3'd0, 3'd0);
    settle();
    check("t3_issue_stall", 32'(stall), 32'h0);
    tick();
    check("t3_busy_set", 32'(busy), 32'h20);
    set_issue(1'b1, 1'b0, 3'd0, 3'd5, 3'd0);
    set_req(0, 1'b1, 3'd5, 16'h5555);
    settle();
    check("t3_raw_stall", 32'(stall), 32'h1);
    check("t3_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 3'd0, 16'h0000);
    settle();
    check("t3_busy_clr", 32'(busy), 32'h00);
    check("t3_stall_drop", 32'(stall), 32'h0);
    check("t3_we", 32'(WE), 32'h1);
    check("t3_rd", 32'(destination_register), 32'h5);
    tick();
    set_issue(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    settle();
    check("t3_busy_after", 32'(busy), 32'h00);

    // 4. WAW and R7 handling (pointer at 0)
    set_issue(1'b1, 1'b1, 3'd2, 3'd0, 3'd0);
    settle();
    check("t4_first_stall", 32'(stall), 32'h0);
    tick();
    check("t4_busy2", 32'(busy), 32'h04);
    check("t4_waw_stall", 32'(stall), 32'h1);
    tick();
    check("t4_busy_hold", 32'(busy), 32'h04);
    set_issue(1'b1, 1'b1, 3'd7, 3'd7, 3'd0);
    settle();
    check("t4_r7_stall", 32'(stall), 32'h0);
    tick();
    check("t4_r7_busy", 32'(busy), 32'h04);
    set_issue(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    set_req(1, 1'b1, 3'd7, 16'h7777);
    settle();
    check("t4_r7_ready", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 3'd0, 16'h0000);
    settle();
    check("t4_r7_we", 32'(WE), 32'h0);
    check("t4_r7_busy2", 32'(busy), 32'h04);
    set_req(2, 1'b1, 3'd2, 16'h2A2A);
    settle();
    check("t4_clr_ready", 32'(req_ready), 32'b100);
    tick();
    set_req(2, 1'b0, 3'd0, 16'h0000);
    settle();
    check("t4_clr_busy", 32'(busy), 32'h00);
    check("t4_clr_wd", 32'(WD), 32'h2A2A);

    // 5. Simultaneous set/clear on R6 (pointer at 2)
    set_issue(1'b1, 1'b1, 3'd6, 3'd0, 3'd0);
    tick();
    check("t5_busy6", 32'(busy), 32'h40);
    set_req(0, 1'b1, 3'd6, 16'h6666);
    settle();
    check("t5_stall", 32'(stall), 32'h1);
    check("t5_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 1'b0, 3'd0, 16'h0000);
    settle();
    check("t5_busy_clr", 32'(busy), 32'h00);
    check("t5_we_rd", 32'({WE, destination_register}), 32'({1'b1, 3'd6}));
    check("t5_retry_stall", 32'(stall), 32'h0);
    tick();
    set_issue(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    settle();
    check("t5_busy_reset", 32'(busy), 32'h40);

    // 6. Reset mid-operation (pointer at 0)
    set_req(1, 1'b1, 3'd6, 16'h0606);
    settle();
    check("t6_clr_ready", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 1'b0, 3'd0, 16'h0000);
    for (int r = 1; r <= 5; r++) begin
      set_issue(1'b1, 1'b1, 3'(r), 3'd0, 3'd0);
      tick();
    end
    set_issue(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    settle();
    check("t6_busy3e", 32'(busy), 32'h3E);
    set_req(0, 1'b1, 3'd6, 16'hABCD);
    settle();
    check("t6_ready0", 32'(req_ready), 32'b001);
    tick();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, rr_rd[i], rr_data[i]);
    settle();
    check("t6_we_inflight", 32'(WE), 32'h1);
    rst = 1'b1;
    settle();
    check("t6_ready_in_rst", 32'(req_ready), 32'b000);
    tick();
    rst = 1'b0;
    settle();
    check("t6_we", 32'(WE), 32'h0);
    check("t6_busy", 32'(busy), 32'h00);
    check("t6_wd", 32'(WD), 32'h0);
    check("t6_first_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    settle();
    check("t6_first_we", 32'(WE), 32'h1);
    check("t6_first_wd", 32'(WD), 32'h1111);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scalar_writeback_scheduler.md
Name: scalar_writeback_scheduler

Overview:
- Shares the single write port of the scalar register file (8 x 16-bit; R7 supplied externally, not stored) between NREQ write-back requesters, e.g. ALU, load unit and vector-reduce unit.
- Arbitrates requesters round-robin and registers the chosen write onto WE / destination_register / WD.
- Keeps a busy scoreboard of registers with pending write-backs and stalls issue on RAW/WAW hazards.
- Sits between the execution units and the scalar register file.

Parameters:
- NREQ, 3, number of write-back requesters (2..4)
- DW, 16, data width
- AW, 3, register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i holds a write-back
- req_rd  in  NREQ*AW  destination index for requester i (slice i)
- req_data  in  NREQ*DW  write data for requester i (slice i)
- req_ready  out  NREQ  one-hot grant, combinational; handshake completes when valid&ready
- issue_valid  in  1  issue stage wants to dispatch an instruction
- issue_has_rd  in  1  dispatched instruction will write issue_rd
- issue_rd  in  AW  destination of dispatched instruction
- src1, src2  in  AW  source registers of dispatched instruction
- stall  out  1  combinational; issue must hold when 1
- busy  out  8  scoreboard bits, registered
- WE  out  1  register-file write enable, registered
- destination_register  out  AW  registered
- WD  out  DW  registered

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: WE=0, destination_register=0, WD=0, busy=0, RR pointer=NREQ-1, so requester 0 has first priority.
- Arbitration: search order starts at pointer+1 mod NREQ and wraps. The first requester with req_valid=1 gets req_ready=1; all others get 0. At most one grant per cycle.
- Pointer update: pointer is set to the granted index on a grant and holds otherwise.
- req_ready is 0 for all requesters while rst=1.
- Requester rules: a requester keeps req_valid, req_rd and req_data stable until granted. A new request may be presented the cycle after its grant.
- Latency: the grant in cycle t produces WE=1, destination_register=req_rd, WD=req_data in cycle t+1. The register file samples these on the negedge of t+1. With no grant, WE=0 next cycle and destination_register/WD hold their previous values.
- R7 write-back: a granted write-back to index 7 completes the handshake but drives WE=0; R7 is external and never written. Index 7 is never marked busy.
- Scoreboard clear: busy[rd] clears on the posedge at the end of the grant cycle, the same edge WE is registered.
- Stall: stall=1 when issue_valid and any of:
  - busy[src1], or busy[src2] (RAW hazard)
  - issue_has_rd and busy[issue_rd] (WAW hazard)
- Hazard checks on index 7 are never asserted, because busy[7] is always 0.
- Scoreboard set: when issue_valid & !stall & issue_has_rd & issue_rd!=7, busy[issue_rd] is set at the next posedge.
- Same-cycle issue set and grant clear on the same index: set wins and busy stays 1. This is legal only when the clear belongs to the previous producer.
- Same-cycle grant clearing rd x and issue reading x: stall=1 this cycle, because busy is still registered 1. The issue proceeds next cycle. There is no bypass.
- Reset mid-operation: all pending busy bits drop, the pointer returns to NREQ-1, and an in-flight WE is forced to 0 on the next edge. Requesters must re-present after reset.

Test Plan:
1. Single requester: reset, then req_valid[1]=1, rd=3, data=16'hBEEF -> req_ready=3'b010 same cycle; next cycle WE=1, destination_register=3, WD=BEEF; following cycle WE=0.
2. Round-robin fairness: all three requesters valid continuously with rd=1,2,4 -> grant order 0,1,2,0,1,2; WE stays high every cycle; WD matches each granted data one cycle later.
3. Scoreboard RAW: issue rd=5 (accepted, busy[5]=1); next instruction src1=5 -> stall=1. Grant requester with rd=5 -> busy[5]=0 next cycle and stall drops that same cycle.
4. WAW plus R7 handling: issue rd=2 twice back-to-back -> second issue stalls. Issue rd=7 -> no stall, busy unchanged. Write-back to rd=7 -> req_ready=1 but WE=0 next cycle.
5. Simultaneous set/clear: busy[6]=1, grant write-back rd=6 in the same cycle as issue rd=6 -> issue blocked by stall (WAW), busy[6] then 0; retry next cycle -> busy[6]=1.
6. Reset mid-operation: busy=8'h3E, WE=1 in flight, assert rst one cycle -> next cycle WE=0, busy=0, req_ready=0 during reset; first grant after reset goes to requester 0.
